// File: rtl/spi_flash_dma.sv
// spi_flash_dma: read sequencer that borrows the SPI peripheral's CPU-side
// register bus, issues a serial-flash READ command and streams the returned
// 32-bit words to a valid/ready sink.
//
// Ports
//   clk, reset_n                     clock, async active-low reset
//   start, flash_addr, word_count,   job request (latched on accept)
//   ss_sel
//   busy, done                       job status (done is a 1-cycle pulse)
//   out_data, out_valid, out_ready   read-word stream to the sink
//   cpu_*                            CPU request/response (pass-through in IDLE)
//   spi_*                            SPI peripheral register bus
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | bus passed through to the CPU, waiting for start
// DRAIN  | let a CPU-started transfer finish shifting
// CFG    | write control reg: 32-bit size, slave select, big-endian
// LOAD   | load command word or all-ones dummy word
// TRIG   | read of data reg starts the transfer
// WAIT   | wait for shifting to finish
// OUT    | hold word for the sink until accepted
// FIN    | one-cycle done pulse
module spi_flash_dma #(
  parameter logic [7:0] READ_CMD = 8'h03
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [23:0] flash_addr,
  input  logic [15:0] word_count,
  input  logic [1:0]  ss_sel,
  output logic        busy,
  output logic        done,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        cpu_select,
  input  logic [3:0]  cpu_we,
  input  logic        cpu_rd,
  input  logic [1:0]  cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_wbusy,
  output logic        cpu_rbusy,
  output logic        spi_select,
  output logic [3:0]  spi_we,
  output logic        spi_rd,
  output logic [1:0]  spi_addr,
  output logic [31:0] spi_wdata,
  input  logic [31:0] spi_rdata,
  input  logic        spi_wbusy,
  input  logic        spi_rbusy
);

  typedef enum logic [2:0] {
    S_IDLE, S_DRAIN, S_CFG, S_LOAD, S_TRIG, S_WAIT, S_OUT, S_FIN
  } state_t;

  state_t      state;
  logic [23:0] addr_q;
  logic [1:0]  ss_q;
  logic [15:0] count;
  logic        cmd_phase;   // next/current transfer carries the READ command

  // Controller's view of the peripheral bus, registered so each value is
  // present exactly during the state that owns it.
  logic        bus_select;
  logic [3:0]  bus_we;
  logic        bus_rd;
  logic [1:0]  bus_addr;
  logic [31:0] bus_wdata;

  logic idle;
  assign idle = (state == S_IDLE);

  assign spi_select = idle ? cpu_select : bus_select;
  assign spi_we     = idle ? cpu_we     : bus_we;
  assign spi_rd     = idle ? cpu_rd     : bus_rd;
  assign spi_addr   = idle ? cpu_addr   : bus_addr;
  assign spi_wdata  = idle ? cpu_wdata  : bus_wdata;
  // Outside IDLE any CPU access simply stalls until the job ends.
  assign cpu_rdata  = idle ? spi_rdata  : 32'd0;
  assign cpu_wbusy  = idle ? spi_wbusy  : cpu_select;
  assign cpu_rbusy  = idle ? spi_rbusy  : cpu_select;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      addr_q     <= 24'd0;
      ss_q       <= 2'd0;
      count      <= 16'd0;
      cmd_phase  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      out_data   <= 32'd0;
      out_valid  <= 1'b0;
      bus_select <= 1'b0;
      bus_we     <= 4'd0;
      bus_rd     <= 1'b0;
      bus_addr   <= 2'd0;
      bus_wdata  <= 32'd0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            addr_q    <= flash_addr;
            ss_q      <= ss_sel;
            count     <= word_count;
            cmd_phase <= 1'b1;
            busy      <= 1'b1;
            if (word_count == 16'd0) begin
              state <= S_FIN;
              done  <= 1'b1;
            end else begin
              state      <= S_DRAIN;
              bus_select <= 1'b1;
              bus_addr   <= 2'd0;
              bus_we     <= 4'd0;
              bus_rd     <= 1'b0;
              bus_wdata  <= 32'd0;
            end
          end
        end
        S_DRAIN: begin
          if (!spi_wbusy) begin
            state     <= S_CFG;
            bus_addr  <= 2'd2;
            bus_we    <= 4'b0111;
            bus_wdata <= {15'd0, 1'b1, 7'd0, ss_q, 5'd0, 2'b11};
          end
        end
        S_CFG: begin
          state     <= S_LOAD;
          bus_addr  <= 2'd1;
          bus_we    <= 4'b1111;
          bus_wdata <= {READ_CMD, addr_q};
        end
        S_LOAD: begin
          state     <= S_TRIG;
          bus_addr  <= 2'd0;
          bus_we    <= 4'd0;
          bus_rd    <= 1'b1;
          bus_wdata <= 32'd0;
        end
        S_TRIG: begin
          state  <= S_WAIT;
          bus_rd <= 1'b0;
        end
        S_WAIT: begin
          if (!spi_wbusy) begin
            if (cmd_phase) begin
              // Data shifted in during the command is meaningless.
              cmd_phase <= 1'b0;
              state     <= S_LOAD;
              bus_addr  <= 2'd1;
              bus_we    <= 4'b1111;
              bus_wdata <= 32'hFFFF_FFFF;
            end else begin
              out_data   <= spi_rdata;
              out_valid  <= 1'b1;
              state      <= S_OUT;
              bus_select <= 1'b0;
            end
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            count     <= count - 16'd1;
            if (count == 16'd1) begin
              state <= S_FIN;
              done  <= 1'b1;
            end else begin
              state      <= S_LOAD;
              bus_select <= 1'b1;
              bus_addr   <= 2'd1;
              bus_we     <= 4'b1111;
              bus_wdata  <= 32'hFFFF_FFFF;
            end
          end
        end
        S_FIN: begin
          state      <= S_IDLE;
          busy       <= 1'b0;
          bus_select <= 1'b0;
          bus_we     <= 4'd0;
          bus_rd     <= 1'b0;
          bus_addr   <= 2'd0;
          bus_wdata  <= 32'd0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_dma.sv
// Directed bench for spi_flash_dma with a simple SPI peripheral/flash model.
module tb_spi_flash_dma;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [23:0] flash_addr;
  logic [15:0] word_count;
  logic [1:0]  ss_sel;
  logic        busy, done, out_valid, out_ready;
  logic [31:0] out_data;
  logic        cpu_select, cpu_rd;
  logic [3:0]  cpu_we;
  logic [1:0]  cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        cpu_wbusy, cpu_rbusy;
  logic        spi_select, spi_rd;
  logic [3:0]  spi_we;
  logic [1:0]  spi_addr;
  logic [31:0] spi_wdata, spi_rdata;
  logic        spi_wbusy, spi_rbusy;

  always #5 clk = ~clk;

  spi_flash_dma #(.READ_CMD(8'h03)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .flash_addr(flash_addr),
    .word_count(word_count), .ss_sel(ss_sel), .busy(busy), .done(done),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .cpu_select(cpu_select), .cpu_we(cpu_we), .cpu_rd(cpu_rd),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_wbusy(cpu_wbusy), .cpu_rbusy(cpu_rbusy), .spi_select(spi_select),
    .spi_we(spi_we), .spi_rd(spi_rd), .spi_addr(spi_addr),
    .spi_wdata(spi_wdata), .spi_rdata(spi_rdata), .spi_wbusy(spi_wbusy),
    .spi_rbusy(spi_rbusy)
  );

  // Peripheral + flash model: 32 busy cycles per transfer, returns resp[] in order.
  logic [31:0] resp [0:7];
  logic        model_clr;
  int          shift_cnt = 0, xfer_idx = 0, load_cnt = 0, sel_cnt = 0;
  int          done_cnt = 0, cyc = 0, trig_cyc = 0, cfg_cyc = 0, trig_seen = 0;
  logic [31:0] rdata_r = 32'd0, first_load = 32'd0, second_load = 32'd0;
  logic [31:0] cfg_wdata_seen = 32'd0;
  logic [3:0]  cfg_we_seen = 4'd0;
  logic [31:0] got [$];

  assign spi_wbusy = (shift_cnt != 0) && spi_select && (spi_addr == 2'd0);
  assign spi_rbusy = spi_wbusy;
  assign spi_rdata = rdata_r;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (model_clr) begin
      shift_cnt <= 0; xfer_idx <= 0; load_cnt <= 0; sel_cnt <= 0;
      done_cnt <= 0; trig_seen <= 0; cfg_cyc <= 0; trig_cyc <= 0;
      cfg_wdata_seen <= 32'd0; cfg_we_seen <= 4'd0;
      got.delete();
    end else begin
      if (shift_cnt != 0) shift_cnt <= shift_cnt - 1;
      else if (spi_select && spi_addr == 2'd0 && (spi_rd || spi_we != 4'd0)) begin
        shift_cnt <= 32;
        rdata_r   <= resp[xfer_idx[2:0]];
        xfer_idx  <= xfer_idx + 1;
        if (trig_seen == 0) begin
          trig_seen <= 1;
          trig_cyc  <= cyc;
        end
      end
      if (spi_select) sel_cnt <= sel_cnt + 1;
      if (spi_select && spi_addr == 2'd1 && spi_we != 4'd0) begin
        if (load_cnt == 0) first_load <= spi_wdata;
        if (load_cnt == 1) second_load <= spi_wdata;
        load_cnt <= load_cnt + 1;
      end
      if (spi_select && spi_addr == 2'd2 && spi_we != 4'd0) begin
        cfg_wdata_seen <= spi_wdata;
        cfg_we_seen    <= spi_we;
        cfg_cyc        <= cyc;
      end
      if (done) done_cnt <= done_cnt + 1;
      if (out_valid && out_ready) got.push_back(out_data);
    end
  end

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    model_clr = 1'b1;
    tick();
    model_clr = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lim);
    int found;
    found = 0;
    for (int i = 0; i < lim; i++) begin
      tick();
      if (done) begin
        found = 1;
        break;
      end
    end
    chk(tag, found, 1);
  endtask

  task automatic do_start(input logic [23:0] a, input logic [15:0] wc, input logic [1:0] ss);
    flash_addr = a; word_count = wc; ss_sel = ss; start = 1'b1;
    tick();
    start = 1'b0; flash_addr = 24'hFFFFFF; word_count = 16'h5555; ss_sel = 2'd3;
  endtask

  initial begin
    int found, stable, lc, n;
    logic [31:0] d0;
    reset_n = 1'b0; start = 1'b0; flash_addr = '0; word_count = '0; ss_sel = '0;
    out_ready = 1'b1; cpu_select = 1'b0; cpu_we = '0; cpu_rd = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; model_clr = 1'b0;
    for (int i = 0; i < 8; i++) resp[i] = 32'd0;

    // Reset state and pass-through
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    cpu_select = 1'b1; cpu_addr = 2'd2; cpu_wdata = 32'h0000_0055; #1;
    chk("rst_pass_sel", spi_select, 1);
    chk("rst_pass_wdata", spi_wdata, 32'h0000_0055);
    cpu_select = 1'b0; cpu_addr = 2'd0; cpu_wdata = '0;
    @(negedge clk); reset_n = 1'b1;
    clear_model();

    // Main job, with an ignored second start mid-job
    resp[0] = 32'h1111_1111; resp[1] = 32'hDEAD_BEEF; resp[2] = 32'h0102_0304;
    do_start(24'h012345, 16'd2, 2'd1);
    chk("main_busy", busy, 1);
    repeat (5) tick();
    flash_addr = 24'h000000; word_count = 16'd0; ss_sel = 2'd0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("main_done_seen", 400);
    repeat (5) tick();
    chk("main_cfg_wdata", cfg_wdata_seen, 32'h0001_0083);
    chk("main_cfg_we", cfg_we_seen, 4'b0111);
    chk("main_cmd_load", first_load, 32'h0301_2345);
    chk("main_dummy_load", second_load, 32'hFFFF_FFFF);
    chk("main_load_cnt", load_cnt, 3);
    chk("main_nwords", got.size(), 2);
    if (got.size() == 2) begin
      chk("main_word0", got[0], 32'hDEAD_BEEF);
      chk("main_word1", got[1], 32'h0102_0304);
    end
    chk("main_done_cnt", done_cnt, 1);
    chk("main_busy_after", busy, 0);
    clear_model();

    // Zero-length job
    do_start(24'h000100, 16'd0, 2'd2);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 1);
    tick();
    chk("zero_done_end", done, 0);
    chk("zero_busy_end", busy, 0);
    chk("zero_no_select", sel_cnt, 0);
    clear_model();

    // Sink backpressure on word 1
    resp[0] = 32'h0; resp[1] = 32'hA5A5_0001; resp[2] = 32'hA5A5_0002;
    out_ready = 1'b0;
    do_start(24'h000000, 16'd2, 2'd0);
    found = 0;
    for (int i = 0; i < 200; i++) begin
      if (out_valid) begin found = 1; break; end
      tick();
    end
    chk("bp_valid_seen", found, 1);
    d0 = out_data; lc = load_cnt; stable = 1;
    repeat (10) begin
      tick();
      if (!out_valid || out_data !== d0) stable = 0;
    end
    chk("bp_stable", stable, 1);
    chk("bp_data", d0, 32'hA5A5_0001);
    chk("bp_no_load", load_cnt, lc);
    chk("bp_cfg_wdata", cfg_wdata_seen, 32'h0001_0003);
    out_ready = 1'b1;
    wait_done("bp_done_seen", 200);
    chk("bp_nwords", got.size(), 2);
    if (got.size() == 2) chk("bp_word1", got[1], 32'hA5A5_0002);
    tick();
    clear_model();

    // CPU transfer in flight at start, CPU stalled during the job
    resp[0] = 32'h0; resp[1] = 32'h0; resp[2] = 32'hCAFE_F00D; resp[3] = 32'h1234_5678;
    cpu_select = 1'b1; cpu_addr = 2'd0; cpu_we = 4'hF; cpu_wdata = 32'h9999_9999;
    tick();
    cpu_we = 4'h0;
    chk("cpu_busy_pre", cpu_wbusy, 1);
    repeat (3) tick();
    do_start(24'h0000AA, 16'd1, 2'd0);
    repeat (60) tick();
    chk("cpu_stall_w", cpu_wbusy, 1);
    chk("cpu_stall_r", cpu_rbusy, 1);
    chk("cpu_stall_rdata", cpu_rdata, 32'd0);
    wait_done("cpu_done_seen", 300);
    chk("drain_cfg_delay", cfg_cyc - trig_cyc, 34);
    chk("cpu_job_word", (got.size() == 1) ? got[0] : 32'hBAD0_BAD0, 32'hCAFE_F00D);
    tick();
    cpu_we = 4'hF;
    tick();
    cpu_we = 4'h0;
    n = 0;
    while (cpu_wbusy && n < 100) begin tick(); n++; end
    chk("cpu_after_len", n, 32);
    chk("cpu_after_rdata", cpu_rdata, 32'h1234_5678);
    cpu_select = 1'b0;
    clear_model();

    // Reset in the middle of WAIT
    do_start(24'h000010, 16'd1, 2'd1);
    found = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (spi_rd) begin found = 1; break; end
    end
    chk("rw_trig_seen", found, 1);
    repeat (3) tick();
    chk("rw_sel_before", spi_select, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rw_busy", busy, 0);
    chk("rw_done", done, 0);
    chk("rw_valid", out_valid, 0);
    chk("rw_data", out_data, 0);
    chk("rw_sel", spi_select, 0);
    cpu_select = 1'b1; cpu_addr = 2'd1; cpu_wdata = 32'h0000_ABCD; #1;
    chk("rw_pass_wdata", spi_wdata, 32'h0000_ABCD);
    chk("rw_pass_addr", spi_addr, 2'd1);
    cpu_select = 1'b0; cpu_addr = 2'd0; cpu_wdata = '0;
    @(negedge clk); reset_n = 1'b1;
    tick();
    chk("rw_idle_after", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
